piso_4: RTL and testbench
=========================

# piso_4

Parallel-in serial-out converter for the block floating point datapath; the transmit-side counterpart of the 4-word SIPO collector. It captures four `bit_size` words in one handshake and emits them one per accepted beat over a valid/ready stream, oldest lane (`in0`) first, flagging the fourth beat with `out_last`. Feeding its stream into a 4-word SIPO reproduces the original lane order (`in0` lands on `out0`).

## Interface
- `bit_size`, default 16: width of every data word.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in3, in2, in1, in0` input `bit_size` each: parallel words; `in0` is sent first, `in3` last.
- `in_valid` input 1: parallel group present.
- `in_ready` output 1: block accepts the group this cycle.
- `out_data` output `bit_size`: current serial word.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream consumes `out_data` this cycle.
- `out_last` output 1: high with the fourth word of a group.

## Operation
- Handshakes complete on a rising edge where valid and ready are both high: load = `in_valid & in_ready`; beat = `out_valid & out_ready`.
- FSM states:
  - `IDLE`: holding registers empty; `out_valid=0`.
  - `SEND`: words pending; `out_valid=1`.
- Transitions:
  - `IDLE`: on load, capture `in0..in3` into holding registers `h0..h3`, set beat counter `cnt=0`, go to `SEND`.
  - `SEND`, beat with `cnt<3`: shift `h0<=h1`, `h1<=h2`, `h2<=h3`, `cnt<=cnt+1`.
  - `SEND`, beat with `cnt==3`: if a load occurs in the same cycle, capture the new group, `cnt<=0`, stay in `SEND`; otherwise go to `IDLE`.
- Output assignments:
  - `out_data = h0` (registered word).
  - `out_last = (state==SEND) & (cnt==3)`.
  - `in_ready = (state==IDLE) | (state==SEND & cnt==3 & out_ready)`. This is a combinational path from `out_ready`, allowed for back-to-back groups.
- With `out_ready` low in `SEND`: `out_data`, `out_last` and `cnt` hold steady, and `out_valid` does not drop.
- Input words are not checked; the block serialises them verbatim. Exponent and mantissa fields pass through unchanged.
- `cnt` is 2 bits. It never wraps in normal operation because the beat at 3 either reloads or exits.
- Reset, from any state including mid-group: `state=IDLE`, `cnt=0`, `h0..h3=0`, so `out_data=0`, `out_valid=0`, `out_last=0`, `in_ready=1` from the cycle after reset deasserts. The partially sent group is discarded, and reset wins over a simultaneous load.

## Timing
- Load-to-first-word latency is 1 cycle: load at edge N, `out_valid=1` with `in0` after edge N.
- Sustained throughput is 1 word/cycle with `out_ready` held high; a group occupies exactly 4 cycles.
- Back-to-back groups have no bubble: the second group's `in0` appears the cycle after the first group's `out_last` beat.
- Idle gap: with `in_valid` low at the last beat, `out_valid` falls the next cycle, and `in_ready` stays 1 in `IDLE`.
- `in_ready` is 0 in `SEND` whenever `cnt<3` or `out_ready=0`; `in_valid` asserted then is ignored until ready.

## Structure
- Shared package `bfp_pkg` holds:
  - FSM state encoding (`IDLE=1'b0`, `SEND=1'b1`),
  - lane-count constant `BFP_LANES=4` and counter width `BFP_CNT_W=2`,
  - the default word width 16, shared with the SIPO.
- The holding registers may reuse the existing `register` cell (enable = load | beat, with a mux on D). No other sub-module; FSM, counter and muxing stay in `piso_4`.

## Test plan
- Reset, then single group `in0..in3=16'h0001,16'h0002,16'h0003,16'h0004` with `out_ready=1` -> `out_data` 0001,0002,0003,0004 on 4 consecutive cycles, `out_last` only on 0004, then `out_valid=0`.
- Backpressure: same group, `out_ready` low for 3 cycles after the second beat -> 0002 held with `out_valid=1`, `cnt` unchanged, `in_ready=0`; the stream resumes with 0003.
- Back-to-back: second group `16'hA000..16'hA003` held valid during the first group -> `in_ready=1` only on the 0004 beat; 8 words on 8 consecutive cycles with no gap, `out_last` on 0004 and A003.
- Reset mid-group after 2 beats -> next cycle `out_valid=0`, `out_data=0`, `in_ready=1`; a new group starts cleanly from its `in0`.
- Loopback into the 4-word SIPO (enable = beat) with random words and random `out_ready` -> after each `out_last` beat, SIPO `out0..out3` equals the original `in0..in3`.
- `in_valid` pulsed while in `SEND` with `cnt<3` -> input ignored, serial stream unchanged.

Source files
------------

// File: rtl/bfp_pkg.sv
// Shared definitions for the block floating point serialiser/collector pair:
// FSM encoding, lane count, beat counter width and default word width.
package bfp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } bfp_state_e;

  localparam int BFP_LANES  = 4;
  localparam int BFP_CNT_W  = 2;
  localparam int BFP_WORD_W = 16;

  // True when the counter points at the final lane of a group.
  function automatic logic bfp_is_last(input logic [BFP_CNT_W-1:0] cnt);
    return cnt == BFP_CNT_W'(BFP_LANES - 1);
  endfunction

endpackage

// File: rtl/piso_4_register.sv
// Enabled holding register with synchronous active-high clear.
module piso_4_register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/piso_4.sv
// 4-word parallel-in serial-out: in0 first, out_last on the fourth beat; first word 1 cycle after load.
// out_ready low freezes the word and counter; in_ready opens only when idle or on the final accepted beat.
module piso_4
  import bfp_pkg::*;
#(
  parameter int bit_size = BFP_WORD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [bit_size-1:0] in3,
  input  logic [bit_size-1:0] in2,
  input  logic [bit_size-1:0] in1,
  input  logic [bit_size-1:0] in0,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [bit_size-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  bfp_state_e             state_q;
  logic [BFP_CNT_W-1:0]   cnt_q;
  logic                   out_valid_q;
  logic                   out_last_q;

  logic                   load;
  logic                   beat;
  logic                   last_beat;
  logic                   h_en;

  logic [bit_size-1:0]    lane_in [BFP_LANES];
  logic [bit_size-1:0]    h_d     [BFP_LANES];
  logic [bit_size-1:0]    h_q     [BFP_LANES];

  assign lane_in[0] = in0;
  assign lane_in[1] = in1;
  assign lane_in[2] = in2;
  assign lane_in[3] = in3;

  assign last_beat = bfp_is_last(cnt_q);
  assign beat      = out_valid_q & out_ready;
  // Combinational path from out_ready lets the next group load on the last beat with no bubble.
  assign in_ready  = (state_q == IDLE) | ((state_q == SEND) & last_beat & out_ready);
  assign load      = in_valid & in_ready;
  assign h_en      = load | beat;

  // Shift toward h0 on a beat, zero-filling the top so an exhausted group leaves clean registers.
  always_comb begin
    for (int i = 0; i < BFP_LANES - 1; i++) begin
      h_d[i] = load ? lane_in[i] : h_q[i+1];
    end
    h_d[BFP_LANES-1] = load ? lane_in[BFP_LANES-1] : '0;
  end

  for (genvar g = 0; g < BFP_LANES; g++) begin : g_hold
    piso_4_register #(.W(bit_size)) u_hold (
      .clk   (clk),
      .reset (reset),
      .en_i  (h_en),
      .d_i   (h_d[g]),
      .q_o   (h_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q     <= SEND;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        SEND: begin
          if (beat) begin
            if (last_beat) begin
              cnt_q      <= '0;
              out_last_q <= 1'b0;
              if (!load) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
              end
            end else begin
              cnt_q      <= cnt_q + BFP_CNT_W'(1);
              out_last_q <= (cnt_q == BFP_CNT_W'(BFP_LANES - 2));
            end
          end
        end
      endcase
    end
  end

  assign out_data  = h_q[0];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_piso_4.sv
// Bench for piso_4: directed cycle checks plus a scoreboard and SIPO reassembly model fed from handshakes.
module tb_piso_4;

  logic        clk;
  logic        reset;
  logic [15:0] in3, in2, in1, in0;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  piso_4 #(.bit_size(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in3       (in3),
    .in2       (in2),
    .in1       (in1),
    .in0       (in0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } beat_t;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       exp_q[$];
  logic [63:0] grp_q[$];
  logic [15:0] sipo [4];
  logic        loaded_flag = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  // Handshake-driven scoreboard and 4-word SIPO model; inputs are stable from +1 through the next edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      grp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("sb_data", 64'(out_data), 64'(e.d));
          check("sb_last", 64'(out_last), 64'(e.last));
        end
        sipo[0] = sipo[1];
        sipo[1] = sipo[2];
        sipo[2] = sipo[3];
        sipo[3] = out_data;
        if (out_last) begin
          if (grp_q.size() == 0) begin
            check("sipo_underflow", 64'(grp_q.size()), 64'd1);
          end else begin
            check("sipo_group", {sipo[3], sipo[2], sipo[1], sipo[0]}, grp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{d: in0, last: 1'b0});
        exp_q.push_back('{d: in1, last: 1'b0});
        exp_q.push_back('{d: in2, last: 1'b0});
        exp_q.push_back('{d: in3, last: 1'b1});
        grp_q.push_back({in3, in2, in1, in0});
        loaded_flag = 1'b1;
      end
    end
  end

  logic [15:0] g1 [4];
  logic [15:0] g2 [4];

  initial begin
    int groups_sent;
    int cyc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_group(16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) sipo[i] = '0;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // Single group, sink always ready.
    set_group(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_valid",    64'(out_valid), 64'd1);
      check("t1_data",     64'(out_data),  64'(k + 1));
      check("t1_last",     64'(out_last),  64'(k == 3));
      check("t1_in_ready", 64'(in_ready),  64'(k == 3));
      step();
    end
    check("t1_idle_valid", 64'(out_valid), 64'd0);
    check("t1_idle_ready", 64'(in_ready),  64'd1);

    // Backpressure after the second beat.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t2_first", 64'(out_data), 64'h0001);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_data",  64'(out_data),  64'h0002);
      check("t2_hold_valid", 64'(out_valid), 64'd1);
      check("t2_hold_last",  64'(out_last),  64'd0);
      check("t2_hold_ready", 64'(in_ready),  64'd0);
      step();
    end
    out_ready = 1'b1;
    check("t2_resume_hold", 64'(out_data), 64'h0002);
    step();
    check("t2_resume_3", 64'(out_data), 64'h0003);
    step();
    check("t2_resume_4", 64'(out_data), 64'h0004);
    check("t2_last",     64'(out_last), 64'd1);
    step();
    check("t2_idle", 64'(out_valid), 64'd0);

    // Back-to-back groups, second one held valid throughout the first.
    g1 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    g2 = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    set_group(g1[0], g1[1], g1[2], g1[3]);
    in_valid = 1'b1;
    step();
    set_group(g2[0], g2[1], g2[2], g2[3]);
    for (int k = 0; k < 8; k++) begin
      check("t3_valid",    64'(out_valid), 64'd1);
      check("t3_data",     64'(out_data),  64'((k < 4) ? g1[k] : g2[k-4]));
      check("t3_last",     64'(out_last),  64'(k == 3 || k == 7));
      check("t3_in_ready", 64'(in_ready),  64'(k == 3 || k == 7));
      step();
      if (k == 3) in_valid = 1'b0;
    end
    check("t3_idle", 64'(out_valid), 64'd0);

    // Reset after two beats of a group.
    set_group(16'h0011, 16'h0012, 16'h0013, 16'h0014);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("t4_pre_rst", 64'(out_data), 64'h0013);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_valid", 64'(out_valid), 64'd0);
    check("t4_data",  64'(out_data),  64'd0);
    check("t4_last",  64'(out_last),  64'd0);
    check("t4_ready", 64'(in_ready),  64'd1);
    set_group(16'hB000, 16'hB001, 16'hB002, 16'hB003);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t4_new_data", 64'(out_data), 64'(16'hB000 + k));
      step();
    end
    check("t4_idle", 64'(out_valid), 64'd0);

    // in_valid pulse while cnt<3 must be ignored.
    set_group(16'hC000, 16'hC001, 16'hC002, 16'hC003);
    in_valid = 1'b1;
    step();
    set_group(16'hDEAD, 16'hBEEF, 16'hF00D, 16'hCAFE);
    check("t6_data0", 64'(out_data), 64'hC000);
    check("t6_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    check("t6_data1", 64'(out_data), 64'hC001);
    step();
    check("t6_data2", 64'(out_data), 64'hC002);
    step();
    check("t6_data3", 64'(out_data), 64'hC003);
    step();
    check("t6_idle", 64'(out_valid), 64'd0);

    // Random loopback with random sink stalls.
    groups_sent = 0;
    cyc = 0;
    loaded_flag = 1'b0;
    set_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    in_valid = 1'b1;
    while (cyc < 4000 && !(groups_sent == 20 && !out_valid)) begin
      step();
      cyc++;
      if (loaded_flag) begin
        loaded_flag = 1'b0;
        groups_sent++;
        if (groups_sent < 20)
          set_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        else
          in_valid = 1'b0;
      end
      out_ready = (groups_sent >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    check("lb_groups",  64'(groups_sent), 64'd20);
    check("lb_drained", 64'(out_valid),   64'd0);
    check("sb_empty",   64'(exp_q.size()), 64'd0);
    check("grp_empty",  64'(grp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
